// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// vga_mem_arbiter : one single-port tile RAM shared by display fetch, bulk clear and a writer
// Rev 1.0
// ============================================================================
module vga_mem_arbiter #(
  parameter int unsigned WIDTH_MEM  = 16,
  parameter int unsigned HEIGHT_MEM = 12,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_active,
  input  logic [3:0]        disp_col,
  input  logic [3:0]        disp_row,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_req,
  input  logic [3:0]        wr_col,
  input  logic [3:0]        wr_row,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic [7:0]        mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [7:0] LAST_ADDR = 8'(WIDTH_MEM * HEIGHT_MEM - 1);

  logic [1:0]        state_q, state_d;
  logic              fv_q, fv_d;
  logic [7:0]        last_q, last_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_zero_q, rd_zero_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [7:0]        clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] clr_val_q, clr_val_d;
  logic [7:0]        mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic       fetch_due;
  logic       disp_in_range;
  logic       wr_in_range;
  logic [7:0] disp_addr;
  logic [7:0] wr_addr;

  function automatic logic [7:0] tile_addr(input logic [3:0] row, input logic [3:0] col);
    return 8'(32'(row) * WIDTH_MEM + 32'(col));
  endfunction

  always_comb begin
    disp_addr     = tile_addr(disp_row, disp_col);
    wr_addr       = tile_addr(wr_row, wr_col);
    disp_in_range = (32'(disp_col) < WIDTH_MEM) && (32'(disp_row) < HEIGHT_MEM);
    wr_in_range   = (32'(wr_col) < WIDTH_MEM) && (32'(wr_row) < HEIGHT_MEM);
    fetch_due     = disp_active && (!fv_q || ({disp_row, disp_col} != last_q));
  end

  always_comb begin
    state_d     = state_q;
    fv_d        = fv_q;
    last_d      = last_q;
    rd_pend_d   = 1'b0;
    rd_zero_d   = 1'b0;
    disp_data_d = disp_data_q;
    clr_cnt_d   = clr_cnt_q;
    clr_val_d   = clr_val_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we      = 1'b0;
    wr_ack      = 1'b0;
    wr_err      = 1'b0;

    // RAM data for last cycle's fetch is valid now; out-of-range fetches land as zero.
    if (rd_pend_q && disp_active) begin
      disp_data_d = rd_zero_q ? '0 : mem_rdata;
    end

    if (!disp_active) begin
      fv_d = 1'b0;
    end else if (fetch_due) begin
      fv_d      = 1'b1;
      last_d    = {disp_row, disp_col};
      rd_pend_d = 1'b1;
      rd_zero_d = !disp_in_range;
      if (disp_in_range) begin
        mem_addr_d = disp_addr;
      end
    end

    // IDLE never touches the RAM, so its decisions are not stalled and a clr_start pulse is never lost.
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d   = ST_CLEAR;
          clr_val_d = clr_value;
          clr_cnt_d = 8'd0;
        end else if (wr_req) begin
          state_d = ST_WRITE;
        end
      end
      ST_CLEAR: begin
        if (!fetch_due) begin
          mem_we      = 1'b1;
          mem_addr_d  = clr_cnt_q;
          mem_wdata_d = clr_val_q;
          if (clr_cnt_q == LAST_ADDR) begin
            state_d   = ST_IDLE;
            clr_cnt_d = 8'd0;
          end else begin
            clr_cnt_d = clr_cnt_q + 8'd1;
          end
        end
      end
      ST_WRITE: begin
        if (!fetch_due) begin
          if (wr_req) begin
            wr_ack = 1'b1;
            wr_err = !wr_in_range;
            if (wr_in_range) begin
              mem_we      = 1'b1;
              mem_addr_d  = wr_addr;
              mem_wdata_d = wr_data;
            end
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr  = mem_addr_d;
  assign mem_wdata = mem_wdata_d;
  assign disp_data = disp_data_q;
  assign clr_busy  = (state_q == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fv_q        <= 1'b0;
      last_q      <= 8'd0;
      rd_pend_q   <= 1'b0;
      rd_zero_q   <= 1'b0;
      disp_data_q <= '0;
      clr_cnt_q   <= 8'd0;
      clr_val_q   <= '0;
      mem_addr_q  <= 8'd0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      fv_q        <= fv_d;
      last_q      <= last_d;
      rd_pend_q   <= rd_pend_d;
      rd_zero_q   <= rd_zero_d;
      disp_data_q <= disp_data_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_val_q   <= clr_val_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// tb_vga_mem_arbiter : directed checks of the tile RAM arbiter against a behavioural synchronous RAM.
module tb_vga_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       disp_active;
  logic [3:0] disp_col, disp_row;
  logic [7:0] disp_data;
  logic       wr_req;
  logic [3:0] wr_col, wr_row;
  logic [7:0] wr_data;
  logic       wr_ack, wr_err;
  logic       clr_start;
  logic [7:0] clr_value;
  logic       clr_busy;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] ram [256];
  logic       preload = 1'b1;
  logic       log_en  = 1'b0;
  logic [7:0] log_addr [$];
  logic [7:0] log_data [$];

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;
  int ack_in_busy = 0;
  int ack_c = -1;
  int bad = 0;

  vga_mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .disp_active(disp_active),
    .disp_col   (disp_col),
    .disp_row   (disp_row),
    .disp_data  (disp_data),
    .wr_req     (wr_req),
    .wr_col     (wr_col),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .clr_start  (clr_start),
    .clr_value  (clr_value),
    .clr_busy   (clr_busy),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Tile RAM: 0xFF everywhere except 0xA5 at address 35 until preload drops.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 35) ? 8'hA5 : 8'hFF;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (log_en && mem_we && clr_busy) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; disp_active = 1'b0; disp_col = 4'd0; disp_row = 4'd0;
    wr_req = 1'b0; wr_col = 4'd0; wr_row = 4'd0; wr_data = 8'd0;
    clr_start = 1'b0; clr_value = 8'd0;

    tick(); preload = 1'b0;
    tick(); reset = 1'b0; settle();
    check("rst_disp_data", 32'(disp_data), 0);
    check("rst_wr_ack",    32'(wr_ack), 0);
    check("rst_wr_err",    32'(wr_err), 0);
    check("rst_clr_busy",  32'(clr_busy), 0);
    check("rst_mem_we",    32'(mem_we), 0);
    check("rst_mem_addr",  32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);

    // Display fetch of tile (col 3,row 2) = address 35
    tick(); disp_active = 1'b1; disp_col = 4'd3; disp_row = 4'd2; settle();
    check("fetch_addr", 32'(mem_addr), 35);
    check("fetch_we",   32'(mem_we), 0);
    tick(); settle();
    check("fetch_hold_addr", 32'(mem_addr), 35);
    check("disp_data_lat1",  32'(disp_data), 0);
    tick(); settle();
    check("disp_data_lat2",  32'(disp_data), 32'h A5);

    // Writer to (15,11) = 191, then immediate out-of-range request (15,12)
    tick(); disp_active = 1'b0; wr_req = 1'b1; wr_col = 4'd15; wr_row = 4'd11; wr_data = 8'h3C; settle();
    check("wr_ack_req_cycle", 32'(wr_ack), 0);
    tick(); settle();
    check("wr_ack",    32'(wr_ack), 1);
    check("wr_err_ok", 32'(wr_err), 0);
    check("wr_we",     32'(mem_we), 1);
    check("wr_addr",   32'(mem_addr), 191);
    check("wr_wdata",  32'(mem_wdata), 32'h3C);
    tick(); wr_row = 4'd12; settle();
    check("no_back_to_back_ack", 32'(wr_ack), 0);
    check("disp_hold_inactive",  32'(disp_data), 32'hA5);
    tick(); settle();
    check("err_ack", 32'(wr_ack), 1);
    check("err_err", 32'(wr_err), 1);
    check("err_we",  32'(mem_we), 0);
    tick(); wr_req = 1'b0; settle();
    check("err_ack_drop", 32'(wr_ack), 0);
    check("err_err_drop", 32'(wr_err), 0);
    check("ram_191", 32'(ram[191]), 32'h3C);

    // Conflict: tile change while WRITE is pending wins the RAM for one cycle
    tick(); disp_active = 1'b1; disp_col = 4'd3; disp_row = 4'd2;
    wr_req = 1'b1; wr_col = 4'd1; wr_row = 4'd0; wr_data = 8'h5A; settle();
    check("cf_fetch0_addr", 32'(mem_addr), 35);
    check("cf_fetch0_ack",  32'(wr_ack), 0);
    tick(); disp_col = 4'd4; settle();
    check("cf_fetch1_addr", 32'(mem_addr), 36);
    check("cf_fetch1_we",   32'(mem_we), 0);
    check("cf_fetch1_ack",  32'(wr_ack), 0);
    tick(); settle();
    check("cf_ack",   32'(wr_ack), 1);
    check("cf_we",    32'(mem_we), 1);
    check("cf_addr",  32'(mem_addr), 1);
    check("cf_wdata", 32'(mem_wdata), 32'h5A);
    check("cf_disp0", 32'(disp_data), 32'hA5);
    tick(); wr_req = 1'b0; settle();
    check("cf_disp1", 32'(disp_data), 32'hFF);

    // Out-of-range display tile (col 0,row 12)
    tick(); disp_col = 4'd0; disp_row = 4'd12; settle();
    check("oor_we",   32'(mem_we), 0);
    check("oor_addr", 32'(mem_addr), 1);
    tick(); settle();
    check("oor_disp_lat1", 32'(disp_data), 32'hFF);
    tick(); settle();
    check("oor_disp_lat2", 32'(disp_data), 0);

    // Bulk clear with writer waiting, one display fetch and an ignored clr_start
    tick(); disp_active = 1'b0; clr_start = 1'b1; clr_value = 8'h07;
    wr_req = 1'b1; wr_col = 4'd2; wr_row = 4'd0; wr_data = 8'h99; log_en = 1'b1; settle();
    check("clr_busy_c0", 32'(clr_busy), 0);
    check("clr_ack_c0",  32'(wr_ack), 0);
    for (int c = 1; c < 400; c++) begin
      tick();
      clr_start   = (c == 80);
      clr_value   = (c == 80) ? 8'h66 : 8'h55;
      disp_active = (c == 40);
      disp_col    = 4'd5;
      disp_row    = 4'd1;
      settle();
      if (c == 1) begin
        check("clr_busy_c1",  32'(clr_busy), 1);
        check("clr_addr_c1",  32'(mem_addr), 0);
        check("clr_wdata_c1", 32'(mem_wdata), 32'h07);
      end
      if (c == 40) begin
        check("clr_fetch_we",   32'(mem_we), 0);
        check("clr_fetch_addr", 32'(mem_addr), 21);
      end
      if (clr_busy) begin
        busy_cnt++;
        if (wr_ack) ack_in_busy++;
      end
      if (wr_ack) begin
        ack_c = c;
        check("post_clr_addr",  32'(mem_addr), 2);
        check("post_clr_wdata", 32'(mem_wdata), 32'h99);
        break;
      end
    end
    tick(); wr_req = 1'b0; log_en = 1'b0; settle();
    check("clr_busy_cycles", 32'(busy_cnt), 193);
    check("clr_ack_in_busy", 32'(ack_in_busy), 0);
    check("clr_ack_cycle",   32'(ack_c), 195);
    check("clr_write_count", 32'(log_addr.size()), 192);
    for (int i = 0; i < log_addr.size(); i++) begin
      if (log_addr[i] != 8'(i) || log_data[i] != 8'h07) bad++;
    end
    check("clr_order_errors", 32'(bad), 0);
    check("ram_0",   32'(ram[0]), 32'h07);
    check("ram_21",  32'(ram[21]), 32'h07);
    check("ram_2",   32'(ram[2]), 32'h99);
    check("ram_191_clr", 32'(ram[191]), 32'h07);

    // Reset while the clear is at address 100
    tick(); clr_start = 1'b1; clr_value = 8'h3E; settle();
    for (int c = 1; c <= 100; c++) begin
      tick(); clr_start = 1'b0; settle();
    end
    tick(); reset = 1'b1; settle();
    check("rc_addr_100", 32'(mem_addr), 100);
    tick(); reset = 1'b0; settle();
    check("rc_busy",  32'(clr_busy), 0);
    check("rc_we",    32'(mem_we), 0);
    check("rc_addr",  32'(mem_addr), 0);
    repeat (3) tick();
    settle();
    check("rc_busy_later", 32'(clr_busy), 0);
    check("rc_ram_99",  32'(ram[99]), 32'h3E);
    check("rc_ram_101", 32'(ram[101]), 32'h07);
    check("rc_ram_191", 32'(ram[191]), 32'h07);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- WIDTH_MEM, 16, tile columns.
- HEIGHT_MEM, 12, tile rows.
- DATA_W, 8, tile data width.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- disp_active, in, 1, VGA visible area.
- disp_col, in, 4, display tile column from the adapter.
- disp_row, in, 4, display tile row from the adapter.
- disp_data, out, DATA_W, registered tile data to the VGA controller.
- wr_req, in, 1, writer request.
- wr_col, in, 4, writer tile column.
- wr_row, in, 4, writer tile row.
- wr_data, in, DATA_W, writer data.
- wr_ack, out, 1, one-cycle writer acknowledge.
- wr_err, out, 1, one-cycle out-of-range flag.
- clr_start, in, 1, bulk-clear start pulse.
- clr_value, in, DATA_W, bulk-clear fill value.
- clr_busy, out, 1, bulk clear in progress.
- mem_addr, out, 8, tile RAM address.
- mem_we, out, 1, tile RAM write enable.
- mem_wdata, out, DATA_W, tile RAM write data.
- mem_rdata, in, DATA_W, tile RAM read data (single-port synchronous RAM, 1-cycle read latency).
REQ-003 There SHALL be one clock, clk; reset SHALL be synchronous and active-high, named reset.

Function
REQ-004 Address mapping SHALL be mem_addr = row*WIDTH_MEM + col, computed at 8 bits; the default range is 0..191.
REQ-005 A display fetch SHALL become due when disp_active=1 and either no tile has been fetched since disp_active rose, or {disp_row,disp_col} differs from the last fetched coordinates.
REQ-006 Fetch rules:
- A due fetch SHALL issue mem_addr with mem_we=0 in the same cycle it is due.
- The fetched coordinates SHALL be recorded as last fetched.
- disp_data SHALL load mem_rdata on the following cycle (2-cycle total latency from the coordinate change).
REQ-007 If the display coordinates are out of range (col>=WIDTH_MEM or row>=HEIGHT_MEM), no RAM access SHALL occur and disp_data SHALL load 0 on the next cycle.
REQ-008 When disp_active=0, the fetched-valid flag SHALL clear and disp_data SHALL hold its value.
REQ-009 Per-cycle RAM priority SHALL be: display fetch > bulk clear > writer. Exactly one requester SHALL own the RAM per cycle.
REQ-010 The state machine SHALL have states IDLE, CLEAR, WRITE:
- IDLE->CLEAR on clr_start.
- IDLE->WRITE on wr_req with no clr_start.
- WRITE->IDLE after the ack cycle.
- CLEAR->IDLE after address (WIDTH_MEM*HEIGHT_MEM-1) is written.
- A display fetch SHALL stall the current state for that cycle without changing it.
REQ-011 Writer handshake:
- wr_req and the wr_* fields SHALL be held stable by the writer until wr_ack.
- wr_ack SHALL pulse for exactly 1 cycle, coincident with mem_we=1, mem_addr and mem_wdata=wr_data.
- A new request SHALL NOT be acknowledged in the cycle immediately following an ack.
REQ-012 An out-of-range writer request SHALL receive wr_ack=1 and wr_err=1 in the same cycle, with mem_we=0.
REQ-013 Bulk clear:
- clr_value SHALL be sampled on the cycle clr_start is accepted.
- clr_busy SHALL be 1 from the next cycle.
- Addresses 0..191 SHALL be written in ascending order, one per cycle the RAM is not taken by a display fetch.
- clr_busy SHALL fall the cycle after the last write.
REQ-014 clr_start SHALL be ignored while clr_busy=1 or while in WRITE. wr_req SHALL wait, unacknowledged, during CLEAR.
REQ-015 If clr_start and wr_req are asserted in the same IDLE cycle, the clear SHALL win and the writer SHALL wait.
REQ-016 When no requester owns the RAM, mem_we SHALL be 0, and mem_addr and mem_wdata SHALL hold their previous values.

Reset
REQ-017 On reset=1 at a clk edge, the following SHALL apply:
- state=IDLE.
- disp_data=0, wr_ack=0, wr_err=0, clr_busy=0, mem_we=0, mem_addr=0, mem_wdata=0.
- fetched-valid=0, clear counter=0.
REQ-018 Reset asserted mid-clear or mid-write SHALL abort the operation with no further writes. Partially cleared contents SHALL remain as written.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Display fetch: disp_active=1, col=3, row=2 -> mem_addr=35, mem_we=0 that cycle; RAM returns 0xA5 -> disp_data=0xA5 two cycles after the coordinate change.
- Writer write: wr_req with col=15, row=11, data=0x3C, display idle -> wr_ack=1, mem_we=1, mem_addr=191, mem_wdata=0x3C in one cycle.
- Writer error: wr_req with col=15, row=12 -> wr_ack=1, wr_err=1, mem_we=0.
- Conflict: display tile change in the same cycle as a pending wr_req -> display read first, wr_ack one cycle later.
- Bulk clear: clr_start with clr_value=0x07 and one display fetch interleaved -> 192 writes of 0x07 to addresses 0..191 in order; clr_busy high for 193 cycles; wr_req held during clear is acknowledged only after clr_busy falls.
- Reset at clear address 100 -> clr_busy=0, mem_we=0 next cycle; no write to address 101.
